// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst address generator: validates one AW/AR-style request, then walks its
// beats one handshake at a time, presenting address, byte-lane window, strobe and last flag.
module axi_burst_addr_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 12,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int LANE_W     = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_WIDTH-1:0]   req_id,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic [2:0]            req_size,
  input  logic [1:0]            req_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [STRB_WIDTH-1:0] beat_strb,
  output logic [LANE_W-1:0]     beat_lo_lane,
  output logic [LANE_W-1:0]     beat_hi_lane,
  output logic [7:0]            beat_num,
  output logic                  beat_last,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam int         MAX_SIZE   = $clog2(STRB_WIDTH);

  state_e                state_q;
  logic                  req_ready_q, beat_valid_q, busy_q, err_valid_q, last_q;
  logic [1:0]            err_code_q, burst_q;
  logic [ID_WIDTH-1:0]   beat_id_q;
  logic [ADDR_WIDTH-1:0] beat_addr_q, wrap_mask_q;
  logic [STRB_WIDTH-1:0] beat_strb_q;
  logic [LANE_W-1:0]     lo_q, hi_q;
  logic [7:0]            num_q, len_q;
  logic [2:0]            size_q;

  logic [31:0]           req_nb, req_aligned, req_last_byte;
  logic [1:0]            req_err_d;
  logic [ADDR_WIDTH-1:0] wrap_mask_d, nb_d, nxt_addr_d;

  function automatic logic [LANE_W-1:0] lo_lane(input logic [ADDR_WIDTH-1:0] a);
    return LANE_W'(32'(a) % STRB_WIDTH);
  endfunction

  // Upper lane is the end of the size-aligned slot, even when the start is unaligned.
  function automatic logic [LANE_W-1:0] hi_lane(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [2:0] size);
    logic [31:0] slot;
    slot = (32'(a) >> size) << size;
    return LANE_W'((slot % STRB_WIDTH) + (32'd1 << size) - 32'd1);
  endfunction

  function automatic logic [STRB_WIDTH-1:0] strb_mask(input logic [LANE_W-1:0] lo,
                                                      input logic [LANE_W-1:0] hi);
    logic [STRB_WIDTH-1:0] m;
    for (int i = 0; i < STRB_WIDTH; i++) m[i] = (i >= int'(lo)) && (i <= int'(hi));
    return m;
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    req_nb        = 32'd1 << req_size;
    req_aligned   = (32'(req_addr) >> req_size) << req_size;
    req_last_byte = req_aligned + (32'(req_len) + 32'd1) * req_nb - 32'd1;
    wrap_mask_d   = ADDR_WIDTH'((32'(req_len) + 32'd1) * req_nb - 32'd1);
    req_err_d     = 2'b00;
    if (32'(req_size) > 32'(MAX_SIZE)) begin
      req_err_d = 2'b01;
    end else if (req_burst == 2'b11 ||
                 (req_burst == BURST_WRAP &&
                  (!(req_len inside {8'd1, 8'd3, 8'd7, 8'd15}) || req_aligned != 32'(req_addr)))) begin
      req_err_d = 2'b10;
    end else if (req_burst == BURST_INCR && ADDR_WIDTH > 12 &&
                 (req_aligned >> 12) != (req_last_byte >> 12)) begin
      req_err_d = 2'b11;
    end
  end

  // WRAP keeps the upper address bits and lets the in-window offset roll over.
  always_comb begin
    nb_d       = ADDR_WIDTH'(32'd1 << size_q);
    nxt_addr_d = beat_addr_q;
    case (burst_q)
      BURST_INCR: nxt_addr_d = (beat_addr_q & ~(nb_d - 1'b1)) + nb_d;
      BURST_WRAP: nxt_addr_d = (beat_addr_q & ~wrap_mask_q) | ((beat_addr_q + nb_d) & wrap_mask_q);
      default:    nxt_addr_d = beat_addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      beat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= 2'b00;
      beat_id_q    <= '0;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      num_q        <= '0;
      last_q       <= 1'b0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      wrap_mask_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      err_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            if (req_err_d != 2'b00) begin
              err_valid_q <= 1'b1;
              err_code_q  <= req_err_d;
            end else begin
              state_q      <= BURST;
              req_ready_q  <= 1'b0;
              beat_valid_q <= 1'b1;
              busy_q       <= 1'b1;
              beat_id_q    <= req_id;
              beat_addr_q  <= req_addr;
              lo_q         <= lo_lane(req_addr);
              hi_q         <= hi_lane(req_addr, req_size);
              beat_strb_q  <= strb_mask(lo_lane(req_addr), hi_lane(req_addr, req_size));
              num_q        <= 8'd0;
              last_q       <= (req_len == 8'd0);
              len_q        <= req_len;
              size_q       <= req_size;
              burst_q      <= req_burst;
              wrap_mask_q  <= wrap_mask_d;
            end
          end
        end
        BURST: begin
          if (beat_ready) begin
            if (last_q) begin
              state_q      <= IDLE;
              beat_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              req_ready_q  <= 1'b1;
            end else begin
              num_q       <= num_q + 8'd1;
              last_q      <= (num_q + 8'd1 == len_q);
              beat_addr_q <= nxt_addr_d;
              lo_q        <= lo_lane(nxt_addr_d);
              hi_q        <= hi_lane(nxt_addr_d, size_q);
              beat_strb_q <= strb_mask(lo_lane(nxt_addr_d), hi_lane(nxt_addr_d, size_q));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign beat_valid   = beat_valid_q;
  assign busy         = busy_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign beat_id      = beat_id_q;
  assign beat_addr    = beat_addr_q;
  assign beat_strb    = beat_strb_q;
  assign beat_lo_lane = lo_q;
  assign beat_hi_lane = hi_q;
  assign beat_num     = num_q;
  assign beat_last    = last_q;

endmodule
